// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decoded instruction, forward sources, stage control
// and the ALU-facing outputs of the ID/EX register.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [RIDX_W-1:0] id_rs1;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [XLEN-1:0]   id_rs1_val;
    logic [XLEN-1:0]   id_rs2_val;
    logic [XLEN-1:0]   id_imm;
    logic              id_alusrc;
    logic [4:0]        id_aluop;
    logic [RIDX_W-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;

    logic [RIDX_W-1:0] exm_rd;
    logic              exm_regwrite;
    logic [XLEN-1:0]   exm_result;
    logic [RIDX_W-1:0] wb_rd;
    logic              wb_regwrite;
    logic [XLEN-1:0]   wb_data;

    logic              flush;
    logic              mem_stall;
    logic              id_stall;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [4:0]        ex_aluop;
    logic [RIDX_W-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [XLEN-1:0]   ex_a;
    logic [XLEN-1:0]   ex_b;
    logic [XLEN-1:0]   ex_store_data;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2,
               id_rs1_val, id_rs2_val, id_imm, id_alusrc, id_aluop, id_rd,
               id_regwrite, id_memread, id_memwrite,
               exm_rd, exm_regwrite, exm_result, wb_rd, wb_regwrite, wb_data,
               flush, mem_stall,
        input  id_stall, ex_valid, ex_pc, ex_aluop, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_a, ex_b, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2,
               id_rs1_val, id_rs2_val, id_imm, id_alusrc, id_aluop, id_rd,
               id_regwrite, id_memread, id_memwrite,
               exm_rd, exm_regwrite, exm_result, wb_rd, wb_regwrite, wb_data,
               flush, mem_stall,
        output id_stall, ex_valid, ex_pc, ex_aluop, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_a, ex_b, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time WB bypass, execute-side operand forwarding,
// load-use bubble insertion, branch flush and memory-stage hold.
module id_ex_stage #(
    parameter int         XLEN      = 32,
    parameter int         RIDX_W    = 5,
    parameter logic [4:0] ALUOP_NOP = 5'd0
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic                         valid;
        logic [XLEN-1:0]              pc;
        logic [4:0]                   aluop;
        logic [RIDX_W-1:0]            rd;
        logic                         regwrite;
        logic                         memread;
        logic                         memwrite;
        logic                         alusrc;
        logic [1:0][RIDX_W-1:0]       rs;
        logic [1:0][XLEN-1:0]         val;
        logic [XLEN-1:0]              imm;
    } ex_fields_t;

    ex_fields_t fields_reg;
    ex_fields_t fields_next;
    ex_fields_t bubble;

    // Operand 0 is rs1, operand 1 is rs2.
    logic [1:0][RIDX_W-1:0] id_rs;
    logic [1:0]             id_use;
    logic [1:0][XLEN-1:0]   id_val;
    logic [1:0][XLEN-1:0]   cap_val;
    logic [1:0][XLEN-1:0]   fwd_val;
    logic [1:0]             dep_hit;
    logic                   luh;

    assign id_rs[0]  = bus.id_rs1;
    assign id_rs[1]  = bus.id_rs2;
    assign id_use[0] = bus.id_use1;
    assign id_use[1] = bus.id_use2;
    assign id_val[0] = bus.id_rs1_val;
    assign id_val[1] = bus.id_rs2_val;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic exm_hit;
            logic wb_hit;
            logic wb_cap_hit;

            assign dep_hit[gi] = id_use[gi] && (id_rs[gi] == fields_reg.rd);

            // The regfile write this cycle is not yet visible on the read port.
            assign wb_cap_hit  = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == id_rs[gi]);
            assign cap_val[gi] = wb_cap_hit ? bus.wb_data : id_val[gi];

            assign exm_hit = bus.exm_regwrite && (bus.exm_rd != '0) && (bus.exm_rd == fields_reg.rs[gi]);
            assign wb_hit  = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == fields_reg.rs[gi]);
            assign fwd_val[gi] = exm_hit ? bus.exm_result :
                                 wb_hit  ? bus.wb_data    :
                                           fields_reg.val[gi];
        end
    endgenerate

    assign luh = fields_reg.valid && fields_reg.memread && (fields_reg.rd != '0) &&
                 bus.id_valid && (|dep_hit);

    // A taken branch kills the dependent instruction, so it need not wait.
    assign bus.id_stall = bus.mem_stall || (luh && !bus.flush);

    always_comb begin
        bubble       = '0;
        bubble.aluop = ALUOP_NOP;
    end

    always_comb begin
        fields_next = fields_reg;
        if (bus.mem_stall) begin
            fields_next = fields_reg;
        end else if (bus.flush || luh || !bus.id_valid) begin
            fields_next = bubble;
        end else begin
            fields_next.valid    = 1'b1;
            fields_next.pc       = bus.id_pc;
            fields_next.aluop    = bus.id_aluop;
            fields_next.rd       = bus.id_rd;
            fields_next.regwrite = bus.id_regwrite;
            fields_next.memread  = bus.id_memread;
            fields_next.memwrite = bus.id_memwrite;
            fields_next.alusrc   = bus.id_alusrc;
            fields_next.rs       = id_rs;
            fields_next.val      = cap_val;
            fields_next.imm      = bus.id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fields_reg <= bubble;
        end else begin
            fields_reg <= fields_next;
        end
    end

    assign bus.ex_valid      = fields_reg.valid;
    assign bus.ex_pc         = fields_reg.pc;
    assign bus.ex_aluop      = fields_reg.aluop;
    assign bus.ex_rd         = fields_reg.rd;
    assign bus.ex_regwrite   = fields_reg.regwrite;
    assign bus.ex_memread    = fields_reg.memread;
    assign bus.ex_memwrite   = fields_reg.memwrite;
    assign bus.ex_a          = fwd_val[0];
    assign bus.ex_b          = fields_reg.alusrc ? fields_reg.imm : fwd_val[1];
    assign bus.ex_store_data = fwd_val[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus a randomized run checked against a transaction-level model
// of the ID/EX register.
module tb_id_ex_stage;
    localparam int         XLEN   = 32;
    localparam int         RIDX_W = 5;
    localparam logic [4:0] NOP    = 5'd0;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    id_ex_stage_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W), .ALUOP_NOP(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what instruction currently sits in EX, as the decoder handed it over.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic        rw, mr, mw, alusrc;
        logic [4:0]  rs1, rs2;
        logic [31:0] v1, v2, imm;
    } slot_t;

    slot_t m;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 1'b0; s.pc = '0; s.aluop = NOP; s.rd = '0;
        s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.alusrc = 1'b0;
        s.rs1 = '0; s.rs2 = '0; s.v1 = '0; s.v2 = '0; s.imm = '0;
        return s;
    endfunction

    function automatic logic [31:0] regfile_read(logic [4:0] idx, logic [31:0] port_val);
        if (bus.wb_regwrite && idx != 0 && bus.wb_rd == idx) return bus.wb_data;
        return port_val;
    endfunction

    function automatic slot_t decoded_slot();
        slot_t s;
        s.valid = 1'b1; s.pc = bus.id_pc; s.aluop = bus.id_aluop; s.rd = bus.id_rd;
        s.rw = bus.id_regwrite; s.mr = bus.id_memread; s.mw = bus.id_memwrite;
        s.alusrc = bus.id_alusrc; s.rs1 = bus.id_rs1; s.rs2 = bus.id_rs2;
        s.v1 = regfile_read(bus.id_rs1, bus.id_rs1_val);
        s.v2 = regfile_read(bus.id_rs2, bus.id_rs2_val);
        s.imm = bus.id_imm;
        return s;
    endfunction

    function automatic logic load_use();
        return m.valid && m.mr && m.rd != 0 && bus.id_valid &&
               ((bus.id_use1 && bus.id_rs1 == m.rd) || (bus.id_use2 && bus.id_rs2 == m.rd));
    endfunction

    function automatic logic [31:0] newest_value(logic [4:0] idx, logic [31:0] held);
        if (idx == 0) return held;
        if (bus.exm_regwrite && bus.exm_rd == idx) return bus.exm_result;
        if (bus.wb_regwrite && bus.wb_rd == idx) return bus.wb_data;
        return held;
    endfunction

    always @(posedge clk) begin
        if (rst) m <= empty_slot();
        else if (bus.mem_stall) m <= m;
        else if (bus.flush || load_use() || !bus.id_valid) m <= empty_slot();
        else m <= decoded_slot();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_use1 = 0; bus.id_use2 = 0; bus.id_rs1_val = '0; bus.id_rs2_val = '0;
        bus.id_imm = '0; bus.id_alusrc = 0; bus.id_aluop = NOP; bus.id_rd = '0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
        bus.exm_rd = '0; bus.exm_regwrite = 0; bus.exm_result = '0;
        bus.wb_rd = '0; bus.wb_regwrite = 0; bus.wb_data = '0;
        bus.flush = 0; bus.mem_stall = 0;
    endtask

    task automatic decode(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [4:0] rd, input logic rw,
                          input logic mr);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_use1 = u1; bus.id_use2 = u2; bus.id_rs1_val = v1; bus.id_rs2_val = v2;
        bus.id_rd = rd; bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = 0;
        bus.id_alusrc = 0; bus.id_imm = '0; bus.id_aluop = 5'd1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset ex_valid: got %b want 0", bus.ex_valid); end
        total++; if (bus.ex_aluop !== NOP) begin bad++; $display("FAIL reset ex_aluop: got %h want %h", bus.ex_aluop, NOP); end
        total++; if (bus.ex_a !== 32'h0) begin bad++; $display("FAIL reset ex_a: got %h want 0", bus.ex_a); end
        total++; if (bus.ex_b !== 32'h0) begin bad++; $display("FAIL reset ex_b: got %h want 0", bus.ex_b); end
        total++; if (bus.ex_regwrite !== 1'b0) begin bad++; $display("FAIL reset ex_regwrite: got %b want 0", bus.ex_regwrite); end
        rst = 0;
        $display("txn reset: ex_valid=%0b ex_aluop=%h", bus.ex_valid, bus.ex_aluop);
    endtask

    task automatic test_forward();
        idle();
        decode(32'h10, 5'd5, 5'd0, 1, 0, 32'hAAAA, 32'h0, 5'd6, 1, 0);
        tick();
        bus.id_valid = 0;
        bus.exm_rd = 5; bus.exm_regwrite = 1; bus.exm_result = 32'h1234;
        bus.wb_rd = 5; bus.wb_regwrite = 1; bus.wb_data = 32'hFFFF;
        #1;
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL fwd ex_valid: got %b want 1", bus.ex_valid); end
        total++; if (bus.ex_a !== 32'h1234) begin bad++; $display("FAIL fwd_exm ex_a: got %h want 00001234", bus.ex_a); end
        bus.exm_regwrite = 0;
        #1;
        total++; if (bus.ex_a !== 32'hFFFF) begin bad++; $display("FAIL fwd_wb ex_a: got %h want 0000ffff", bus.ex_a); end
        bus.wb_regwrite = 0;
        #1;
        total++; if (bus.ex_a !== 32'hAAAA) begin bad++; $display("FAIL fwd_none ex_a: got %h want 0000aaaa", bus.ex_a); end
        decode(32'h14, 5'd0, 5'd9, 0, 1, 32'h0, 32'h1, 5'd10, 1, 0);
        bus.wb_rd = 9; bus.wb_regwrite = 1; bus.wb_data = 32'h5555;
        tick();
        bus.wb_regwrite = 0; bus.id_valid = 0;
        #1;
        total++; if (bus.ex_b !== 32'h5555) begin bad++; $display("FAIL capture_bypass ex_b: got %h want 00005555", bus.ex_b); end
        total++; if (bus.ex_store_data !== 32'h5555) begin bad++; $display("FAIL capture_bypass store: got %h want 00005555", bus.ex_store_data); end
        $display("txn forward: ex_a=%h ex_b=%h", bus.ex_a, bus.ex_b);
    endtask

    task automatic test_load_use();
        idle();
        decode(32'h40, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 5'd7, 1, 1);
        tick();
        decode(32'h44, 5'd7, 5'd1, 1, 1, 32'h0, 32'h0, 5'd8, 1, 0);
        #1;
        total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL luh id_stall: got %b want 1", bus.id_stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL luh bubble ex_valid: got %b want 0", bus.ex_valid); end
        total++; if (bus.ex_memread !== 1'b0) begin bad++; $display("FAIL luh bubble ex_memread: got %b want 0", bus.ex_memread); end
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL luh release id_stall: got %b want 0", bus.id_stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8) begin bad++; $display("FAIL luh load: got valid=%b rd=%0d want valid=1 rd=8", bus.ex_valid, bus.ex_rd); end
        $display("txn load_use: ex_pc=%h ex_rd=%0d", bus.ex_pc, bus.ex_rd);
    endtask

    task automatic test_flush();
        idle();
        decode(32'h80, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 5'd7, 1, 1);
        tick();
        decode(32'h84, 5'd7, 5'd0, 1, 0, 32'h0, 32'h0, 5'd3, 1, 0);
        bus.flush = 1;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL flush_luh id_stall: got %b want 0", bus.id_stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0) begin bad++; $display("FAIL flush bubble: got valid=%b rw=%b want 0 0", bus.ex_valid, bus.ex_regwrite); end
        bus.flush = 0;
        decode(32'h88, 5'd3, 5'd0, 1, 0, 32'h0, 32'h0, 5'd9, 1, 0);
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9) begin bad++; $display("FAIL post_flush load: got valid=%b rd=%0d want 1 9", bus.ex_valid, bus.ex_rd); end
        $display("txn flush: ex_valid=%0b ex_rd=%0d", bus.ex_valid, bus.ex_rd);
    endtask

    task automatic test_hold();
        idle();
        decode(32'h100, 5'd1, 5'd2, 1, 1, 32'h0, 32'h0, 5'd4, 1, 0);
        bus.id_aluop = 5'd3;
        tick();
        decode(32'h104, 5'd1, 5'd2, 1, 1, 32'h0, 32'h0, 5'd5, 1, 0);
        bus.flush = 1; bus.mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL hold id_stall[%0d]: got %b want 1", i, bus.id_stall); end
            tick();
            total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h100 || bus.ex_rd !== 5'd4 || bus.ex_aluop !== 5'd3)
                begin bad++; $display("FAIL hold fields[%0d]: got v=%b pc=%h rd=%0d op=%h want 1 100 4 03", i, bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_aluop); end
        end
        bus.mem_stall = 0;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL hold release id_stall: got %b want 0", bus.id_stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL hold late flush: got %b want 0", bus.ex_valid); end
        bus.flush = 0;
        decode(32'h200, 5'd1, 5'd2, 1, 1, 32'h0, 32'h0, 5'd6, 1, 0);
        tick();
        bus.mem_stall = 1; rst = 1;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0) begin bad++; $display("FAIL reset_in_stall: got v=%b rd=%0d want 0 0", bus.ex_valid, bus.ex_rd); end
        rst = 0; bus.mem_stall = 0;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL reset_in_stall id_stall: got %b want 0", bus.id_stall); end
        $display("txn hold: ex_valid=%0b", bus.ex_valid);
    endtask

    task automatic test_x0_imm();
        idle();
        decode(32'h20, 5'd0, 5'd3, 1, 1, 32'h77, 32'h33, 5'd11, 1, 0);
        bus.id_alusrc = 1; bus.id_imm = 32'hFFFFF800;
        bus.exm_rd = 0; bus.exm_regwrite = 1; bus.exm_result = 32'hDEAD;
        bus.wb_rd = 0; bus.wb_regwrite = 1; bus.wb_data = 32'hBEEF;
        tick();
        bus.id_valid = 0;
        #1;
        total++; if (bus.ex_a !== 32'h77) begin bad++; $display("FAIL x0 ex_a: got %h want 00000077", bus.ex_a); end
        total++; if (bus.ex_b !== 32'hFFFFF800) begin bad++; $display("FAIL imm ex_b: got %h want fffff800", bus.ex_b); end
        total++; if (bus.ex_store_data !== 32'h33) begin bad++; $display("FAIL imm store: got %h want 00000033", bus.ex_store_data); end
        bus.exm_rd = 3; bus.exm_result = 32'h3333;
        #1;
        total++; if (bus.ex_store_data !== 32'h3333) begin bad++; $display("FAIL imm fwd store: got %h want 00003333", bus.ex_store_data); end
        total++; if (bus.ex_b !== 32'hFFFFF800) begin bad++; $display("FAIL imm fwd ex_b: got %h want fffff800", bus.ex_b); end
        $display("txn x0_imm: ex_a=%h ex_b=%h store=%h", bus.ex_a, bus.ex_b, bus.ex_store_data);
    endtask

    task automatic test_random();
        logic        exp_stall;
        logic [31:0] exp_b;
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 49) == 0);
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_pc        = $urandom;
            bus.id_rs1       = 5'($urandom_range(0, 7));
            bus.id_rs2       = 5'($urandom_range(0, 7));
            bus.id_use1      = 1'($urandom);
            bus.id_use2      = 1'($urandom);
            bus.id_rs1_val   = $urandom;
            bus.id_rs2_val   = $urandom;
            bus.id_imm       = $urandom;
            bus.id_alusrc    = 1'($urandom);
            bus.id_aluop     = 5'($urandom);
            bus.id_rd        = 5'($urandom_range(0, 7));
            bus.id_regwrite  = 1'($urandom);
            bus.id_memread   = ($urandom_range(0, 2) == 0);
            bus.id_memwrite  = 1'($urandom);
            bus.exm_rd       = 5'($urandom_range(0, 7));
            bus.exm_regwrite = 1'($urandom);
            bus.exm_result   = $urandom;
            bus.wb_rd        = 5'($urandom_range(0, 7));
            bus.wb_regwrite  = 1'($urandom);
            bus.wb_data      = $urandom;
            bus.flush        = ($urandom_range(0, 5) == 0);
            bus.mem_stall    = ($urandom_range(0, 5) == 0);
            #1;
            exp_stall = bus.mem_stall || (load_use() && !bus.flush);
            exp_b     = m.alusrc ? m.imm : newest_value(m.rs2, m.v2);
            total++; if (bus.id_stall !== exp_stall) begin bad++; $display("FAIL rnd[%0d] id_stall: got %b want %b", n, bus.id_stall, exp_stall); end
            total++; if (bus.ex_valid !== m.valid || bus.ex_pc !== m.pc || bus.ex_aluop !== m.aluop || bus.ex_rd !== m.rd)
                begin bad++; $display("FAIL rnd[%0d] ctl: got v=%b pc=%h op=%h rd=%0d want v=%b pc=%h op=%h rd=%0d", n, bus.ex_valid, bus.ex_pc, bus.ex_aluop, bus.ex_rd, m.valid, m.pc, m.aluop, m.rd); end
            total++; if (bus.ex_regwrite !== m.rw || bus.ex_memread !== m.mr || bus.ex_memwrite !== m.mw)
                begin bad++; $display("FAIL rnd[%0d] flags: got %b%b%b want %b%b%b", n, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, m.rw, m.mr, m.mw); end
            total++; if (bus.ex_a !== newest_value(m.rs1, m.v1)) begin bad++; $display("FAIL rnd[%0d] ex_a: got %h want %h", n, bus.ex_a, newest_value(m.rs1, m.v1)); end
            total++; if (bus.ex_b !== exp_b) begin bad++; $display("FAIL rnd[%0d] ex_b: got %h want %h", n, bus.ex_b, exp_b); end
            total++; if (bus.ex_store_data !== newest_value(m.rs2, m.v2)) begin bad++; $display("FAIL rnd[%0d] store: got %h want %h", n, bus.ex_store_data, newest_value(m.rs2, m.v2)); end
            $display("txn rnd %0d: rst=%0b stall=%0b flush=%0b ex_valid=%0b ex_rd=%0d ex_a=%h ex_b=%h",
                     n, rst, bus.id_stall, bus.flush, bus.ex_valid, bus.ex_rd, bus.ex_a, bus.ex_b);
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_flush();
        test_hold();
        test_x0_imm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
